// File: rtl/pulse_train_generator_if.sv
// Bundles the launch handshake, train parameters and generated line of the
// pulse train generator into one port.
interface pulse_train_generator_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
  logic [W-1:0] count;
  logic         a;
  logic         busy;
  logic         done;

  modport master (
    output start, high_len, low_len, count,
    input  a, busy, done
  );

  modport slave (
    input  start, high_len, low_len, count,
    output a, busy, done
  );
endinterface

// File: rtl/pulse_train_generator.sv
// Drives a programmable train of high pulses separated by low gaps on one
// line, launched by start and closed with a one-cycle done strobe.
module pulse_train_generator #(
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pulse_train_generator_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_DONE
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state, state_next;
  logic [W-1:0] phase, phase_next;
  logic [W-1:0] pulses, pulses_next;
  logic [W-1:0] high_q, high_next;
  logic [W-1:0] low_q, low_next;
  logic         a_q, busy_q, done_q;
  logic         a_next, busy_next, done_next;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next  = state;
    phase_next  = phase;
    pulses_next = pulses;
    high_next   = high_q;
    low_next    = low_q;

    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          high_next   = bus.high_len;
          // A zero gap is stretched to one cycle so adjacent pulses stay separable.
          low_next    = (bus.low_len == '0) ? ONE : bus.low_len;
          pulses_next = bus.count;
          phase_next  = bus.high_len;
          state_next  = (bus.count != '0 && bus.high_len != '0) ? S_HIGH : S_DONE;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_HIGH: begin
        if (phase == ONE) begin
          if (pulses > ONE) begin
            state_next  = S_LOW;
            pulses_next = pulses - ONE;
            phase_next  = low_q;
          end else begin
            state_next = S_DONE;
          end
        end else begin
          phase_next = phase - ONE;
        end
      end
      S_LOW: begin
        if (phase == ONE) begin
          state_next = S_HIGH;
          phase_next = high_q;
        end else begin
          phase_next = phase - ONE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered alongside it.
    a_next    = (state_next == S_HIGH);
    busy_next = (state_next == S_HIGH) || (state_next == S_LOW);
    done_next = (state_next == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      phase  <= '0;
      pulses <= '0;
      high_q <= '0;
      low_q  <= '0;
      a_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      phase  <= phase_next;
      pulses <= pulses_next;
      high_q <= high_next;
      low_q  <= low_next;
      a_q    <= a_next;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  assign bus.a    = a_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/pulse_train_generator.md
# pulse_train_generator

Sequential stimulus source that drives a single-bit line `a` with a programmable train of high pulses separated by low gaps. It is the transmitting counterpart of the posedge and one-cycle-pulse detectors. Its output connects directly to a detector's `a` input, so a bench or upstream logic can produce detector stimulus without hand-written bit vectors. A start/busy/done handshake launches a train and reports its completion.

## Interface

Parameters:
- `W`, default 8: width of the length and count fields and of the internal counters.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous reset, active-low. `rst == 0` clears all state immediately, independent of `clk`.
- `start`, input, 1: launch request. Sampled on a rising edge only while the block is not busy.
- `high_len`, input, W: number of cycles each pulse stays high.
- `low_len`, input, W: number of cycles in each gap between pulses.
- `count`, input, W: number of pulses in the train.
- `a`, output, 1: generated pulse line. Registered.
- `busy`, output, 1: a train is in progress. Registered.
- `done`, output, 1: one-cycle completion strobe. Registered.

## Operation

- States:
  - IDLE: `a`=0, `busy`=0, `done`=0.
  - HIGH: `a`=1, `busy`=1.
  - LOW: `a`=0, `busy`=1.
  - DONE: `a`=0, `busy`=0, `done`=1, lasts one cycle.
- Reset value of every output is 0, and the state is IDLE. Reset asserted mid-train aborts the train at once: `a` drops without waiting for a clock edge, and no `done` is produced.
- Launch: in IDLE or DONE, `start`=1 at a rising edge does three things:
  - latches `high_len`, `low_len` and `count`;
  - loads the pulse counter with `count`;
  - loads the phase counter with `high_len`.
- Input changes after launch have no effect on the running train.
- Transitions:
  - IDLE/DONE with `start` and `count`≠0 and `high_len`≠0 -> HIGH.
  - IDLE/DONE with `start` and (`count`=0 or `high_len`=0) -> DONE. Empty train; `a` never rises.
  - DONE without `start` -> IDLE.
  - HIGH, phase counter expires, pulses remaining > 1 -> LOW. Decrement the pulse counter and load the phase counter with the effective `low_len`.
  - HIGH, phase counter expires on the last pulse -> DONE. No trailing gap.
  - LOW, phase counter expires -> HIGH. Load the phase counter with `high_len`.
- The effective gap is `max(low_len, 1)`. `low_len`=0 is treated as 1 so adjacent pulses stay distinguishable to an edge detector.
- `start` in HIGH or LOW is ignored. There is no queueing.
- Counters are W bits and never wrap. All-ones values (2^W−1) are legal and must produce exactly that many cycles or pulses.

## Timing

- Latency: if `start` is sampled at edge E, `a` is 1 in the cycle following E. There is no dead cycle.
- For H=`high_len`, L=effective gap, N=`count` (all nonzero):
  - pulse k (0-based) is high in cycles E+k(H+L) through E+k(H+L)+H−1;
  - `a` is low during each gap;
  - `done`=1 for exactly one cycle starting at edge E+N·H+(N−1)·L, and `a`=0 in that cycle.
- Empty train: `done`=1 in the cycle after E; `a` and `busy` stay 0.
- `busy` rises together with `a` at E and falls together with the rise of `done`.
- Back-to-back: `start`=1 during the DONE cycle launches the next train at the following edge. The first pulse of the new train then immediately follows the `done` cycle, so `a` is low for exactly one cycle between trains.
- Behaviour on DONE and `start` in the same cycle: `done` still pulses for its full cycle.

## Test plan

- H=1, L=2, N=3, start at E: `a` = 1,0,0,1,0,0,1 over cycles E..E+6; `done`=1 at E+7 only. A one-cycle-pulse detector driven by `a` must flag 3 pulses.
- H=3, L=0, N=2: `a` = 1,1,1,0,1,1,1. The single low gap confirms L=0 is treated as 1; `done` at E+7.
- N=0 or H=0: `done`=1 one cycle after E; `a` and `busy` stay 0 throughout.
- Launch H=2, L=2, N=4. Pulse `start` again and change `high_len` to 7 during the third gap. The train must be unaltered at 4 pulses of 2 cycles each, with exactly one `done`.
- Drive `rst`=0 asynchronously mid-HIGH of a train with H=5, N=3. `a`, `busy` and `done` drop to 0 before the next clock edge, and no `done` appears after release. A new start then produces a clean train.
- Issue `start` during DONE, then run W=8 with H=255, N=2, L=1. This checks the back-to-back one-cycle separation and confirms high phases of exactly 255 cycles with no counter wrap.
